registro_universal: RTL
=======================

// Module: registro_universal
// PURPOSE
//  Parametrised universal register: the next generation of our 8-bit enable/reset holding register.
//  Adds hold/load/shift/rotate/count modes, serial I/O, a synchronous clear and status flags.
//  Used as a datapath holding/shift/counter stage between FSM control and data buses.
// PARAMETERS
//  WIDTH        8     register width in bits, >= 2
//  RESET_VALUE  '0    value of data_output after asynchronous reset (WIDTH bits)
// PORTS
//  clk          in   1      single clock, all state updates on posedge
//  reset        in   1      asynchronous, active-high reset
//  clear        in   1      synchronous clear to 0, overrides enable/mode
//  enable       in   1      1 = perform operation selected by mode this edge; 0 = hold
//  mode         in   3      operation select (see BEHAVIOUR)
//  data_input   in   WIDTH  parallel load data
//  serial_in    in   1      bit entering on shift operations
//  data_output  out  WIDTH  register contents (registered)
//  serial_out   out  1      bit shifted/rotated out on the last shift/rotate (registered)
//  zero         out  1      combinational: data_output == 0
//  limit        out  1      registered 1-cycle pulse: count crossed its bound (see below)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-operation): data_output=RESET_VALUE, serial_out=0, limit=0.
//  - Priority per edge: reset > clear > enable. clear: data_output=0, serial_out=0, limit=0.
//  - enable=0 and clear=0: all registers hold; limit returns to 0.
//  - enable=1 modes (Q = data_output, W = WIDTH), result visible 1 cycle after edge:
//      000 HOLD   Q<=Q
//      001 LOAD   Q<=data_input
//      010 SHL    Q<={Q[W-2:0],serial_in}; serial_out<=Q[W-1]
//      011 SHR    Q<={serial_in,Q[W-1:1]}; serial_out<=Q[0]
//      100 ROL    Q<={Q[W-2:0],Q[W-1]};    serial_out<=Q[W-1]
//      101 ROR    Q<={Q[0],Q[W-1:1]};      serial_out<=Q[0]
//      110 CNTUP  Q<=Q+1 (modulo 2^W unless SAT_EN)
//      111 CNTDN  Q<=Q-1 (modulo 2^W unless SAT_EN)
//  - serial_out changes only on shift/rotate edges; it holds in all other modes.
//  - limit: set to 1 for exactly one cycle after any edge where CNTUP starts at all-ones
//    or CNTDN starts at zero; otherwise 0 on every edge. Back-to-back bound hits keep it high.
//  - Mode changes take effect on the next edge; no internal state other than Q/serial_out/limit.
//  - Arithmetic is unsigned, W bits; no carry beyond W is stored.
// CONFIGURATION
//  REGISTRO_UNIVERSAL_SAT_EN defined: counting saturates. CNTUP at all-ones holds all-ones;
//    CNTDN at 0 holds 0. limit still pulses on each such attempt.
//  Not defined: counting wraps (all-ones+1 -> 0, 0-1 -> all-ones), limit pulses on wrap.
// TESTING (WIDTH=8, RESET_VALUE=8'hA5 unless noted)
//  1 assert reset mid-cycle while mode=CNTUP -> data_output=A5, serial_out=0, limit=0 immediately
//  2 LOAD 8'h81, then SHL serial_in=0 x2 -> Q=02 then 04; serial_out=1 then 0
//  3 LOAD 8'h01, ROR x1 -> Q=80, serial_out=1; ROL x1 -> Q=01, serial_out=1
//  4 LOAD FF, CNTUP -> Q=00, limit=1 one cycle, zero=1 (SAT_EN: Q=FF, limit=1, zero=0)
//  5 LOAD 00, CNTDN -> Q=FF, limit=1 (SAT_EN: Q=00, limit=1); next edge enable=0 -> limit=0
//  6 clear=1 with enable=1 mode=LOAD data_input=3C -> Q=00; enable=0 with LOAD -> Q holds

Source files
------------

// File: rtl/registro_universal.sv
`default_nettype none
// ============================================================================
//  Module      : registro_universal
//  Description : Parametrised universal register with hold, parallel load,
//                shift left/right, rotate left/right and up/down count modes.
//                It also provides serial I/O, a synchronous clear and
//                zero/limit status flags.
//                Optional feature macro: REGISTRO_UNIVERSAL_SAT_EN. When it
//                is defined the counters saturate at their bound instead of
//                wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module registro_universal #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_input,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_output,
    output logic             serial_out,
    output logic             zero,
    output logic             limit
);

    localparam logic [2:0] c_MODE_HOLD  = 3'b000;
    localparam logic [2:0] c_MODE_LOAD  = 3'b001;
    localparam logic [2:0] c_MODE_SHL   = 3'b010;
    localparam logic [2:0] c_MODE_SHR   = 3'b011;
    localparam logic [2:0] c_MODE_ROL   = 3'b100;
    localparam logic [2:0] c_MODE_ROR   = 3'b101;
    localparam logic [2:0] c_MODE_CNTUP = 3'b110;
    localparam logic [2:0] c_MODE_CNTDN = 3'b111;

    logic [WIDTH-1:0] r_q;
    logic             r_serial_out;
    logic             r_limit;

    // Bound detection shared by the counter modes.
    logic w_all_ones;
    logic w_is_zero;
    assign w_all_ones = &r_q;
    assign w_is_zero  = (r_q == '0);

    // Register update: async reset, then sync clear, then the enabled mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q          <= RESET_VALUE;
            r_serial_out <= 1'b0;
            r_limit      <= 1'b0;
        end else if (clear) begin
            r_q          <= '0;
            r_serial_out <= 1'b0;
            r_limit      <= 1'b0;
        end else begin
            // limit is a one-cycle pulse; only a counter bound hit raises it
            r_limit <= 1'b0;
            if (enable) begin
                case (mode)
                    c_MODE_HOLD: begin
                        r_q <= r_q;
                    end
                    c_MODE_LOAD: begin
                        r_q <= data_input;
                    end
                    c_MODE_SHL: begin
                        r_q          <= {r_q[WIDTH-2:0], serial_in};
                        r_serial_out <= r_q[WIDTH-1];
                    end
                    c_MODE_SHR: begin
                        r_q          <= {serial_in, r_q[WIDTH-1:1]};
                        r_serial_out <= r_q[0];
                    end
                    c_MODE_ROL: begin
                        r_q          <= {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        r_serial_out <= r_q[WIDTH-1];
                    end
                    c_MODE_ROR: begin
                        r_q          <= {r_q[0], r_q[WIDTH-1:1]};
                        r_serial_out <= r_q[0];
                    end
                    c_MODE_CNTUP: begin
                        r_limit <= w_all_ones;
`ifdef REGISTRO_UNIVERSAL_SAT_EN
                        if (!w_all_ones) begin
                            r_q <= r_q + 1'b1;
                        end
`else
                        r_q <= r_q + 1'b1;
`endif
                    end
                    c_MODE_CNTDN: begin
                        r_limit <= w_is_zero;
`ifdef REGISTRO_UNIVERSAL_SAT_EN
                        if (!w_is_zero) begin
                            r_q <= r_q - 1'b1;
                        end
`else
                        r_q <= r_q - 1'b1;
`endif
                    end
                    default: begin
                        r_q <= r_q;
                    end
                endcase
            end
        end
    end

    assign data_output = r_q;
    assign serial_out  = r_serial_out;
    assign limit       = r_limit;
    assign zero        = w_is_zero;

endmodule
`default_nettype wire
